// File: rtl/div_repsub_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
// Optional feature macro used by this block: DIV_ZERO_FLAG_EN.
package div_pkg;

    localparam int unsigned DIV_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        SUB  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_repsub_if.sv
// Operand/result bus of the divider: start, serial operand input and results.
// div_err is present only when DIV_ZERO_FLAG_EN is defined.
interface div_repsub_if #(
    parameter int unsigned W = div_pkg::DIV_W
);

    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
`ifdef DIV_ZERO_FLAG_EN
    logic         div_err;
`endif

`ifdef DIV_ZERO_FLAG_EN
    modport master (
        output start,
        output data_in,
        input  quotient,
        input  remainder,
        input  done,
        input  div_err
    );

    modport slave (
        input  start,
        input  data_in,
        output quotient,
        output remainder,
        output done,
        output div_err
    );
`else
    modport master (
        output start,
        output data_in,
        input  quotient,
        input  remainder,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output quotient,
        output remainder,
        output done
    );
`endif

endinterface : div_repsub_if

// File: rtl/div_repsub_datapath.sv
// Divider datapath: A/B/Q registers, A>=B compare, subtract, increment,
// plus result registers that hold quotient/remainder between runs.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_i,
    input  logic         ld_a_i,
    input  logic         ld_b_i,
    input  logic         clr_q_i,
    input  logic         set_q_i,
    input  logic         sub_i,
    input  logic         fin_i,
    output logic         ge_o,
    output logic         bz_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] quot_q, quot_d;
    logic [W-1:0] rem_q, rem_d;

    assign ge_o        = (a_q >= b_q);
    assign bz_o        = (data_i == '0);
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        q_d    = q_q;
        quot_d = quot_q;
        rem_d  = rem_q;

        if (ld_a_i) a_d = data_i;
        if (ld_b_i) b_d = data_i;
        if (clr_q_i) q_d = '0;
        if (set_q_i) q_d = '1;
        if (sub_i) begin
            a_d = a_q - b_q;
            q_d = q_q + W'(1);
        end

        // Results are captured on DONE entry so they survive the next LDA load of A.
        if (fin_i) begin
            quot_d = set_q_i ? '1 : q_q;
            rem_d  = a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            q_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            q_q    <= q_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

endmodule : div_datapath

// File: rtl/div_repsub.sv
// Repeated-subtraction unsigned divider: controller FSM around div_datapath.
// Optional DIV_ZERO_FLAG_EN adds the div_err divide-by-zero flag.
module div_repsub
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic        clk,
    input  logic        rst,
    div_repsub_if.slave bus
);

    div_state_e state_q, state_d;

    logic ld_a, ld_b, clr_q, set_q, sub, fin;
    logic ge, bz;

    div_datapath #(
        .W (W)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .data_i      (bus.data_in),
        .ld_a_i      (ld_a),
        .ld_b_i      (ld_b),
        .clr_q_i     (clr_q),
        .set_q_i     (set_q),
        .sub_i       (sub),
        .fin_i       (fin),
        .ge_o        (ge),
        .bz_o        (bz),
        .quotient_o  (bus.quotient),
        .remainder_o (bus.remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        clr_q   = 1'b0;
        set_q   = 1'b0;
        sub     = 1'b0;
        fin     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = LDA;
            end
            LDA: begin
                ld_a    = 1'b1;
                state_d = LDB;
            end
            LDB: begin
                ld_b = 1'b1;
                // A zero divisor bypasses SUB entirely, so the loop can never spin on B=0.
                if (bz) begin
                    set_q   = 1'b1;
                    fin     = 1'b1;
                    state_d = DONE;
                end else begin
                    clr_q   = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (ge) begin
                    sub = 1'b1;
                end else begin
                    fin     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.done = (state_q == DONE);

`ifdef DIV_ZERO_FLAG_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == LDB && bz)
            err_d = 1'b1;
        else if (state_q == DONE && !bus.start)
            err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.div_err = err_q;
`endif

endmodule : div_repsub

// File: doc/div_repsub.md
Name: div_repsub

Overview:
- Repeated-subtraction unsigned divider built as a datapath plus a controller FSM. It is the inverse of the shift-free repeated-addition multiplier.
- Operands arrive serially on one shared data bus: dividend first, then divisor. After a start request, the block produces quotient and remainder with a level done handshake.
- It sits beside the multiplier in the arithmetic-unit group and shares the same load-then-iterate operand protocol.

Parameters:
- W, 16, operand, quotient and remainder width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request. Sampled only in IDLE and DONE.
- data_in  in  W  serial operand bus. Carries the dividend in LDA and the divisor in LDB.
- quotient  out  W  result quotient. Valid while done=1.
- remainder  out  W  result remainder. Valid while done=1.
- done  out  1  high while the FSM is in DONE.
- div_err  out  1  divide-by-zero flag. Exists only with DIV_ZERO_FLAG_EN.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state goes to IDLE.
  - Registers A (dividend/working remainder), B (divisor) and Q all become 0.
  - done=0, quotient=0, remainder=0, div_err=0.
  - rst wins over every other event, including mid-subtraction and in DONE.
- FSM states: IDLE, LDA, LDB, SUB, DONE.
- IDLE: start=1 at an edge moves to LDA. Otherwise stay.
- LDA: at the edge, A <= data_in, then go to LDB. data_in is not checked.
- LDB: at the edge, B <= data_in, Q <= 0, then go to SUB.
  - Exception: data_in==0 follows the divide-by-zero rule below.
- SUB: one compare and one subtract per cycle.
  - If A >= B: A <= A - B, Q <= Q + 1, stay in SUB.
  - Otherwise: go to DONE.
  - Compare and subtract are unsigned and W bits wide. A-B never underflows because it is only taken when A >= B.
  - Q cannot overflow: Q is at most the dividend, which is at most 2^W-1.
- DONE:
  - done=1; quotient=Q; remainder=A.
  - Stay while start=1. A start held high does not retrigger.
  - Move to IDLE on the first edge where start=0.
  - quotient and remainder keep their values through IDLE until the next LDB.
- Latency: let edge k be the edge where start is sampled in IDLE.
  - A is loaded at edge k+1; B at edge k+2.
  - SUB occupies edges k+3 .. k+2+Q.
  - done goes high after edge k+3+Q.
  - Worst case is 2^W+2 cycles (dividend all-ones, divisor 1).
- Divide by zero: if data_in==0 in LDB, set Q <= all-ones, keep A as the dividend, and go straight to DONE at edge k+2.
  - The block never loops on a zero divisor, with or without the macro.
- Other boundaries:
  - Dividend < divisor: Q=0, remainder=dividend, done after edge k+3.
  - Dividend == 0 with a nonzero divisor: Q=0, remainder=0.
  - start toggling during LDA, LDB or SUB is ignored.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - The div_err port exists.
  - div_err is set together with entry to DONE for a zero divisor and holds while done=1.
  - It clears on leaving DONE or on rst.
- Undefined:
  - No div_err port.
  - The zero-divisor result values and timing are identical.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, LDA, LDB, SUB, DONE);
  - the default width constant DIV_W=16.
- One sub-module, div_datapath, is natural. It contains registers A, B and Q, the >= comparator, the subtractor and the incrementer.
  - It is driven by the load/sub strobes ldA, ldB, clrQ and sub.
  - It returns the status signals ge (A>=B) and bz (data_in==0).
- The controller FSM stays in div_repsub.

Test Plan:
- start=1 at edge k; data_in=17 before edge k+1; data_in=5 before edge k+2 -> done rises after edge k+6; quotient=3, remainder=2.
- data_in=5 then 17 -> quotient=0, remainder=5, done after edge k+3.
- data_in=16'hFFFF then 1 -> quotient=16'hFFFF, remainder=0, done after edge k+65538.
- data_in=9 then 0 -> done after edge k+2; quotient=16'hFFFF, remainder=9; div_err=1 with the macro defined; port absent without it.
- rst=1 for one edge during SUB of 100/3 -> next cycle state is IDLE and done/quotient/remainder are all 0. A following 100/3 run returns quotient 33, remainder 1.
- start held high through DONE for 10 cycles -> done stays 1 and there is no retrigger. start=0 -> IDLE next edge, results held.
